// File: rtl/axis_pkg.sv
// +--------------------------------------------------------------------------+
// | axis_pkg : state encodings shared by the AXI-Stream frame FIFO            |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package axis_pkg;

  localparam logic [0:0] ST_WRITE_ENC = 1'b0;
  localparam logic [0:0] ST_DROP_ENC  = 1'b1;

  typedef enum logic [0:0] {
    ST_WRITE = ST_WRITE_ENC,
    ST_DROP  = ST_DROP_ENC
  } wr_state_e;

endpackage

`default_nettype wire

// File: rtl/axis_fifo_ram.sv
// +--------------------------------------------------------------------------+
// | axis_fifo_ram : simple dual-port storage, registered read, tlast on MSB   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module axis_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH:0]   wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH:0]   rd_data
);

  logic [DATA_WIDTH:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/axis_frame_fifo.sv
// +--------------------------------------------------------------------------+
// | axis_frame_fifo : store-and-forward AXI-Stream frame FIFO with drop logic |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module axis_frame_fifo
  import axis_pkg::*;
#(
  parameter int   DATA_WIDTH           = 8,
  parameter int   ADDR_WIDTH           = 6,
  parameter logic USER_BAD_FRAME_VALUE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  overflow,
  output logic                  bad_frame,
  output logic                  good_frame
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH:0]   wr_ptr_cur_q, wr_ptr_cur_d;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  bad_frame_q, bad_frame_d;
  logic                  good_frame_q, good_frame_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;

  logic                  full, empty, beat_in, out_load;
  logic                  ram_wr_en, ram_rd_en;
  logic [DATA_WIDTH:0]   ram_rd_data;

  // Ingress is never throttled; only reset withholds ready.
  assign input_axis_tready = rst;
  assign beat_in           = input_axis_tvalid & rst;

  assign full  = (wr_ptr_cur_q == {~rd_ptr_q[ADDR_WIDTH], rd_ptr_q[ADDR_WIDTH-1:0]});
  assign empty = (wr_ptr_q == rd_ptr_q);

  always_comb begin
    state_d      = state_q;
    wr_ptr_cur_d = wr_ptr_cur_q;
    wr_ptr_d     = wr_ptr_q;
    overflow_d   = 1'b0;
    bad_frame_d  = 1'b0;
    good_frame_d = 1'b0;
    ram_wr_en    = 1'b0;
    case (state_q)
      ST_WRITE: begin
        if (beat_in) begin
          if (!full) begin
            ram_wr_en    = 1'b1;
            wr_ptr_cur_d = wr_ptr_cur_q + PTR_ONE;
            if (input_axis_tlast) begin
              if (input_axis_tuser == USER_BAD_FRAME_VALUE) begin
                wr_ptr_cur_d = wr_ptr_q;
                bad_frame_d  = 1'b1;
              end else begin
                wr_ptr_d     = wr_ptr_cur_q + PTR_ONE;
                good_frame_d = 1'b1;
              end
            end
          end else begin
            // Out of room: rewind the partial frame and swallow its remainder.
            wr_ptr_cur_d = wr_ptr_q;
            overflow_d   = 1'b1;
            if (!input_axis_tlast) begin
              state_d = ST_DROP;
            end
          end
        end
      end
      ST_DROP: begin
        if (beat_in && input_axis_tlast) begin
          state_d = ST_WRITE;
        end
      end
      default: state_d = ST_WRITE;
    endcase
  end

  // Two-stage read pipe: RAM output register feeds the egress register.
  always_comb begin
    out_load    = !out_valid_q || output_axis_tready;
    ram_rd_en   = !empty && (out_load || !mem_valid_q);
    rd_ptr_d    = ram_rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    mem_valid_d = mem_valid_q;
    if (ram_rd_en) begin
      mem_valid_d = 1'b1;
    end else if (out_load) begin
      mem_valid_d = 1'b0;
    end
    out_valid_d = out_load ? mem_valid_q : out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (out_load && mem_valid_q) begin
      out_data_d = ram_rd_data[DATA_WIDTH-1:0];
      out_last_d = ram_rd_data[DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_WRITE;
      wr_ptr_cur_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      bad_frame_q  <= 1'b0;
      good_frame_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_cur_q <= wr_ptr_cur_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      bad_frame_q  <= bad_frame_d;
      good_frame_q <= good_frame_d;
      mem_valid_q  <= mem_valid_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  axis_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_cur_q[ADDR_WIDTH-1:0]),
    .wr_data ({input_axis_tlast, input_axis_tdata}),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

  assign output_axis_tdata  = out_data_q;
  assign output_axis_tvalid = out_valid_q;
  assign output_axis_tlast  = out_last_q;
  assign overflow           = overflow_q;
  assign bad_frame          = bad_frame_q;
  assign good_frame         = good_frame_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_fifo.sv
// +--------------------------------------------------------------------------+
// | tb_axis_frame_fifo : directed self-checking bench, depth 16               |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_axis_frame_fifo;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] input_axis_tdata = '0;
  logic          input_axis_tvalid = 1'b0;
  logic          input_axis_tready;
  logic          input_axis_tlast = 1'b0;
  logic          input_axis_tuser = 1'b0;
  logic [DW-1:0] output_axis_tdata;
  logic          output_axis_tvalid;
  logic          output_axis_tready = 1'b1;
  logic          output_axis_tlast;
  logic          overflow;
  logic          bad_frame;
  logic          good_frame;

  always #5 clk = ~clk;

  axis_frame_fifo #(
    .DATA_WIDTH           (DW),
    .ADDR_WIDTH           (AW),
    .USER_BAD_FRAME_VALUE (1'b1)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (input_axis_tdata),
    .input_axis_tvalid  (input_axis_tvalid),
    .input_axis_tready  (input_axis_tready),
    .input_axis_tlast   (input_axis_tlast),
    .input_axis_tuser   (input_axis_tuser),
    .output_axis_tdata  (output_axis_tdata),
    .output_axis_tvalid (output_axis_tvalid),
    .output_axis_tready (output_axis_tready),
    .output_axis_tlast  (output_axis_tlast),
    .overflow           (overflow),
    .bad_frame          (bad_frame),
    .good_frame         (good_frame)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int good_cnt = 0, bad_cnt = 0, ovf_cnt = 0, excl_cnt = 0;
  int rise_cnt = 0, unstable_cnt = 0, out_cnt = 0;
  int good_cyc = 0, ovf_cyc = 0, rise_cyc = 0;
  logic [DW:0] out_mem  [0:255];
  int          xfer_cyc [0:255];
  logic        prev_valid = 1'b0;
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_beat  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Egress/pulse recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (output_axis_tvalid && !prev_valid) begin
        rise_cnt++;
        rise_cyc = cyc;
      end
      if (prev_stall && output_axis_tvalid && ({output_axis_tlast, output_axis_tdata} !== prev_beat))
        unstable_cnt++;
      if (output_axis_tvalid && output_axis_tready) begin
        if (out_cnt < 256) begin
          out_mem[out_cnt]  = {output_axis_tlast, output_axis_tdata};
          xfer_cyc[out_cnt] = cyc;
        end
        out_cnt++;
      end
      if (good_frame) begin good_cnt++; good_cyc = cyc; end
      if (bad_frame)  bad_cnt++;
      if (overflow)   begin ovf_cnt++; ovf_cyc = cyc; end
      if ((int'(good_frame) + int'(bad_frame) + int'(overflow)) > 1) excl_cnt++;
      prev_valid = output_axis_tvalid;
      prev_stall = output_axis_tvalid && !output_axis_tready;
      prev_beat  = {output_axis_tlast, output_axis_tdata};
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic user);
    input_axis_tdata  = d;
    input_axis_tlast  = last;
    input_axis_tuser  = user;
    input_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    input_axis_tvalid = 1'b0;
    input_axis_tlast  = 1'b0;
    input_axis_tuser  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    checks++; if (output_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", output_axis_tvalid); end
    checks++; if (output_axis_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata got %h want 00", output_axis_tdata); end
    checks++; if (output_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", output_axis_tlast); end
    checks++; if (input_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", input_axis_tready); end
    checks++; if ({overflow, bad_frame, good_frame} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b want 000", {overflow, bad_frame, good_frame}); end
    idle(3);
    rst = 1'b1;
    #1;
    checks++; if (input_axis_tready !== 1'b1) begin errors++; $display("FAIL rel_tready got %b want 1", input_axis_tready); end
    idle(2);
    checks++; if (output_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rel_tvalid got %b want 0", output_axis_tvalid); end
  endtask

  task automatic test_single_frame;
    int base, g0, b0, o0;
    output_axis_tready = 1'b1;
    base = out_cnt; g0 = good_cnt; b0 = bad_cnt; o0 = ovf_cnt;
    send_beat(8'h11, 1'b0, 1'b0);
    send_beat(8'h22, 1'b0, 1'b0);
    send_beat(8'h33, 1'b1, 1'b0);
    idle(8);
    checks++; if (good_cnt - g0 != 1) begin errors++; $display("FAIL single_good got %0d want 1", good_cnt - g0); end
    checks++; if ((bad_cnt - b0) + (ovf_cnt - o0) != 0) begin errors++; $display("FAIL single_other got %0d want 0", (bad_cnt - b0) + (ovf_cnt - o0)); end
    checks++; if (out_cnt - base != 3) begin errors++; $display("FAIL single_count got %0d want 3", out_cnt - base); end
    checks++; if (out_mem[base] !== 9'h011) begin errors++; $display("FAIL single_b0 got %h want 011", out_mem[base]); end
    checks++; if (out_mem[base+1] !== 9'h022) begin errors++; $display("FAIL single_b1 got %h want 022", out_mem[base+1]); end
    checks++; if (out_mem[base+2] !== 9'h133) begin errors++; $display("FAIL single_b2 got %h want 133", out_mem[base+2]); end
    checks++; if (rise_cyc - good_cyc != 2) begin errors++; $display("FAIL single_latency got %0d want 2", rise_cyc - good_cyc); end
  endtask

  task automatic test_bad_frame;
    int base, g0, b0, r0;
    base = out_cnt; g0 = good_cnt; b0 = bad_cnt; r0 = rise_cnt;
    for (int i = 0; i < 5; i++) send_beat(8'hB0 + 8'(i), (i == 4), (i == 4));
    idle(8);
    checks++; if (bad_cnt - b0 != 1) begin errors++; $display("FAIL bad_pulse got %0d want 1", bad_cnt - b0); end
    checks++; if (good_cnt - g0 != 0) begin errors++; $display("FAIL bad_good got %0d want 0", good_cnt - g0); end
    checks++; if (rise_cnt - r0 != 0) begin errors++; $display("FAIL bad_tvalid_rises got %0d want 0", rise_cnt - r0); end
    send_beat(8'h5A, 1'b0, 1'b0);
    send_beat(8'hA5, 1'b1, 1'b0);
    idle(8);
    checks++; if (out_cnt - base != 2) begin errors++; $display("FAIL bad_next_count got %0d want 2", out_cnt - base); end
    checks++; if (out_mem[base] !== 9'h05A) begin errors++; $display("FAIL bad_next_b0 got %h want 05A", out_mem[base]); end
    checks++; if (out_mem[base+1] !== 9'h1A5) begin errors++; $display("FAIL bad_next_b1 got %h want 1A5", out_mem[base+1]); end
  endtask

  task automatic test_overflow;
    int base, g0, o0, c17;
    base = out_cnt; g0 = good_cnt; o0 = ovf_cnt; c17 = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 16) c17 = cyc;
      send_beat(8'(i + 1), (i == 19), 1'b0);
    end
    idle(8);
    checks++; if (ovf_cnt - o0 != 1) begin errors++; $display("FAIL ovf_pulse got %0d want 1", ovf_cnt - o0); end
    checks++; if (ovf_cyc != c17 + 1) begin errors++; $display("FAIL ovf_beat17 got %0d want %0d", ovf_cyc, c17 + 1); end
    checks++; if (out_cnt - base != 0) begin errors++; $display("FAIL ovf_no_output got %0d want 0", out_cnt - base); end
    checks++; if (good_cnt - g0 != 0) begin errors++; $display("FAIL ovf_good got %0d want 0", good_cnt - g0); end
    send_beat(8'hC1, 1'b0, 1'b0);
    send_beat(8'hC2, 1'b1, 1'b0);
    idle(8);
    checks++; if (out_cnt - base != 2) begin errors++; $display("FAIL ovf_next_count got %0d want 2", out_cnt - base); end
    checks++; if (out_mem[base] !== 9'h0C1) begin errors++; $display("FAIL ovf_next_b0 got %h want 0C1", out_mem[base]); end
    checks++; if (out_mem[base+1] !== 9'h1C2) begin errors++; $display("FAIL ovf_next_b1 got %h want 1C2", out_mem[base+1]); end
  endtask

  task automatic test_back_to_back;
    int base, g0;
    logic [DW:0] exp;
    base = out_cnt; g0 = good_cnt;
    output_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(8'h40 + 8'(i), (i == 7), 1'b0);
    for (int i = 0; i < 8; i++) send_beat(8'h80 + 8'(i), (i == 7), 1'b0);
    idle(4);
    checks++; if ({output_axis_tvalid, output_axis_tlast, output_axis_tdata} !== 10'h240) begin errors++; $display("FAIL b2b_stall_head got %h want 240", {output_axis_tvalid, output_axis_tlast, output_axis_tdata}); end
    idle(6);
    checks++; if ({output_axis_tvalid, output_axis_tlast, output_axis_tdata} !== 10'h240) begin errors++; $display("FAIL b2b_stall_hold got %h want 240", {output_axis_tvalid, output_axis_tlast, output_axis_tdata}); end
    checks++; if (good_cnt - g0 != 2) begin errors++; $display("FAIL b2b_good got %0d want 2", good_cnt - g0); end
    output_axis_tready = 1'b1;
    idle(25);
    checks++; if (out_cnt - base != 16) begin errors++; $display("FAIL b2b_count got %0d want 16", out_cnt - base); end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 8) ? {(i == 7), 8'h40 + 8'(i)} : {(i == 15), 8'h80 + 8'(i - 8)};
      checks++; if (out_mem[base+i] !== exp) begin errors++; $display("FAIL b2b_beat%0d got %h want %h", i, out_mem[base+i], exp); end
    end
    checks++; if (xfer_cyc[base+15] - xfer_cyc[base] != 15) begin errors++; $display("FAIL b2b_span got %0d want 15", xfer_cyc[base+15] - xfer_cyc[base]); end
  endtask

  task automatic test_reset_mid_frame;
    int base, g0;
    output_axis_tready = 1'b0;
    send_beat(8'h01, 1'b0, 1'b0);
    send_beat(8'h02, 1'b1, 1'b0);
    idle(4);
    checks++; if (output_axis_tvalid !== 1'b1) begin errors++; $display("FAIL rmf_stored got %b want 1", output_axis_tvalid); end
    send_beat(8'h10, 1'b0, 1'b0);
    send_beat(8'h11, 1'b0, 1'b0);
    input_axis_tdata  = 8'h12;
    input_axis_tvalid = 1'b1;
    #3 rst = 1'b0;
    #1;
    checks++; if ({output_axis_tvalid, output_axis_tlast, output_axis_tdata} !== 10'h000) begin errors++; $display("FAIL rmf_outputs got %h want 000", {output_axis_tvalid, output_axis_tlast, output_axis_tdata}); end
    checks++; if ({overflow, bad_frame, good_frame, input_axis_tready} !== 4'b0000) begin errors++; $display("FAIL rmf_pulses got %b want 0000", {overflow, bad_frame, good_frame, input_axis_tready}); end
    input_axis_tvalid = 1'b0;
    idle(2);
    rst = 1'b1;
    output_axis_tready = 1'b1;
    base = out_cnt; g0 = good_cnt;
    idle(8);
    checks++; if (out_cnt - base != 0) begin errors++; $display("FAIL rmf_stale got %0d want 0", out_cnt - base); end
    send_beat(8'hAA, 1'b1, 1'b0);
    idle(8);
    checks++; if (out_cnt - base != 1) begin errors++; $display("FAIL rmf_count got %0d want 1", out_cnt - base); end
    checks++; if (out_mem[base] !== 9'h1AA) begin errors++; $display("FAIL rmf_beat got %h want 1AA", out_mem[base]); end
    checks++; if (good_cnt - g0 != 1) begin errors++; $display("FAIL rmf_good got %0d want 1", good_cnt - g0); end
  endtask

  task automatic test_invariants;
    checks++; if (excl_cnt != 0) begin errors++; $display("FAIL pulse_exclusive got %0d want 0", excl_cnt); end
    checks++; if (unstable_cnt != 0) begin errors++; $display("FAIL stall_stable got %0d want 0", unstable_cnt); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_bad_frame;
    test_overflow;
    test_back_to_back;
    test_reset_mid_frame;
    test_invariants;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
